// File: rtl/seg7_share_arbiter_if.sv
// Display-share bus: CPU/IR requests in, HXE8 image out.
// master drives requests; slave is the arbiter.
interface seg7_share_arbiter_if;
  logic        cpu_en;
  logic [31:0] cpu_data;
  logic        cpu_wr;
  logic        ir_valid;
  logic [31:0] ir_data;
  logic        en;
  logic [31:0] disp_data;
  logic        owner;
  logic        cpu_pend;

  modport master (
    output cpu_en, cpu_data, cpu_wr,
    output ir_valid, ir_data,
    input  en, disp_data, owner, cpu_pend
  );

  modport slave (
    input  cpu_en, cpu_data, cpu_wr,
    input  ir_valid, ir_data,
    output en, disp_data, owner, cpu_pend
  );
endinterface

// File: rtl/seg7_share_arbiter.sv
// Shares the HXE8 seven-segment driver between CPU PIO and IR decode.
// Ports: Clk, Rst_n (async low), bus (slave): cpu_*/ir_* in, en/disp_data/owner/cpu_pend out.
// Option: SEG7_ARB_CPU_PREEMPT_EN lets cpu_wr abort the IR hold window.
module seg7_share_arbiter #(
  parameter int HOLD_CYCLES = 50000000,
  parameter int CNT_W       = 26
) (
  input  logic Clk,
  input  logic Rst_n,
  seg7_share_arbiter_if.slave bus
);

  typedef enum logic {S_CPU, S_IR} state_t;

  localparam logic [CNT_W-1:0] RELOAD =
    CNT_W'(HOLD_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state         <= S_CPU;
      cnt           <= '0;
      bus.en        <= 1'b0;
      bus.disp_data <= 32'h0;
      bus.owner     <= 1'b0;
      bus.cpu_pend  <= 1'b0;
    end else begin
      unique case (state)
        S_CPU: begin
          if (bus.ir_valid) begin
            state         <= S_IR;
            cnt           <= RELOAD;
            bus.disp_data <= bus.ir_data;
            bus.en        <= 1'b1;
            bus.owner     <= 1'b1;
            bus.cpu_pend  <= bus.cpu_wr;
          end else begin
            bus.disp_data <= bus.cpu_data;
            bus.en        <= bus.cpu_en;
            bus.owner     <= 1'b0;
            bus.cpu_pend  <= 1'b0;
          end
        end
        S_IR: begin
          // A new IR word beats both expiry and the CPU.
          if (bus.ir_valid) begin
            cnt           <= RELOAD;
            bus.disp_data <= bus.ir_data;
            if (bus.cpu_wr)
              bus.cpu_pend <= 1'b1;
          end
`ifdef SEG7_ARB_CPU_PREEMPT_EN
          else if (bus.cpu_wr) begin
            state         <= S_CPU;
            bus.disp_data <= bus.cpu_data;
            bus.en        <= bus.cpu_en;
            bus.owner     <= 1'b0;
            bus.cpu_pend  <= 1'b0;
          end
`endif
          else if (cnt == '0) begin
            state         <= S_CPU;
            bus.disp_data <= bus.cpu_data;
            bus.en        <= bus.cpu_en;
            bus.owner     <= 1'b0;
            bus.cpu_pend  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
            if (bus.cpu_wr)
              bus.cpu_pend <= 1'b1;
          end
        end
        default: state <= S_CPU;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_share_arbiter.sv
// Self-checking bench for seg7_share_arbiter (HOLD_CYCLES=8).
// Directed steps then random traffic against a window-based model.
module tb_seg7_share_arbiter;

  localparam int H    = 8;
  localparam int NONE = -1000000;

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  always #5 Clk = ~Clk;

  seg7_share_arbiter_if bus ();

  seg7_share_arbiter #(
    .HOLD_CYCLES(H),
    .CNT_W      (26)
  ) dut (
    .Clk  (Clk),
    .Rst_n(Rst_n),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  // Model: the IR owns the display for H edges
  // starting at the edge of the latest ir_valid.
  int          cyc = 0;
  int          last_ir = NONE;
  logic [31:0] ir_word = 32'h0;
  logic        m_owner = 1'b0;
  logic        m_pend = 1'b0;
  logic [31:0] e_disp = 32'h0;
  logic        e_en = 1'b0;
  int          own_cnt;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag,
                      input logic ce,
                      input logic [31:0] cd,
                      input logic cw,
                      input logic iv,
                      input logic [31:0] id);
    logic prev;
    logic now;
    @(negedge Clk);
    bus.cpu_en   = ce;
    bus.cpu_data = cd;
    bus.cpu_wr   = cw;
    bus.ir_valid = iv;
    bus.ir_data  = id;
    @(posedge Clk);
    prev = m_owner;
    if (iv) begin
      last_ir = cyc;
      ir_word = id;
    end
`ifdef SEG7_ARB_CPU_PREEMPT_EN
    else if (prev && cw) begin
      last_ir = NONE;
    end
`endif
    now = (cyc - last_ir) < H;
    if (now) begin
      m_pend = (prev ? m_pend : 1'b0) | cw;
      e_disp = ir_word;
      e_en   = 1'b1;
    end else begin
      m_pend = 1'b0;
      e_disp = cd;
      e_en   = ce;
    end
    m_owner = now;
    cyc++;
    #1;
    chk({tag, "_disp"}, bus.disp_data, e_disp);
    chk({tag, "_en"}, 32'(bus.en), 32'(e_en));
    chk({tag, "_owner"}, 32'(bus.owner), 32'(m_owner));
    chk({tag, "_pend"}, 32'(bus.cpu_pend), 32'(m_pend));
  endtask

  task automatic idle(input string tag,
                      input logic [31:0] cd,
                      input int n);
    for (int i = 0; i < n; i++) begin
      step(tag, 1'b1, cd, 1'b0, 1'b0, 32'h0);
      if (bus.owner) own_cnt++;
    end
  endtask

  task automatic model_reset();
    last_ir = NONE;
    m_owner = 1'b0;
    m_pend  = 1'b0;
  endtask

  initial begin
    bus.cpu_en   = 1'b1;
    bus.cpu_data = 32'h12345678;
    bus.cpu_wr   = 1'b0;
    bus.ir_valid = 1'b0;
    bus.ir_data  = 32'h0;

    // reset values
    #22;
    chk("rst_disp", bus.disp_data, 32'h0);
    chk("rst_en", 32'(bus.en), 32'h0);
    chk("rst_owner", 32'(bus.owner), 32'h0);
    chk("rst_pend", 32'(bus.cpu_pend), 32'h0);
    @(negedge Clk);
    Rst_n = 1'b1;

    // S_CPU tracking
    step("t1", 1'b1, 32'h12345678, 1'b0, 1'b0, 32'h0);
    chk("t1_abs", bus.disp_data, 32'h12345678);
    step("t1b", 1'b0, 32'hCAFE0001, 1'b0, 1'b0, 32'h0);

    // hold window
    own_cnt = 0;
    step("t2_ir", 1'b1, 32'h11111111, 1'b0, 1'b1, 32'hA5);
    if (bus.owner) own_cnt++;
    chk("t2_latch", bus.disp_data, 32'hA5);
    idle("t2", 32'h11111111, 10);
    chk("t2_owncnt", own_cnt, H);
    chk("t2_back", bus.disp_data, 32'h11111111);

    // window restart
    own_cnt = 0;
    step("t3_ir1", 1'b1, 32'h22, 1'b0, 1'b1, 32'hA5);
    if (bus.owner) own_cnt++;
    idle("t3a", 32'h22, 4);
    step("t3_ir2", 1'b1, 32'h22, 1'b0, 1'b1, 32'h5A);
    if (bus.owner) own_cnt++;
    chk("t3_relatch", bus.disp_data, 32'h5A);
    idle("t3b", 32'h22, 10);
    chk("t3_owncnt", own_cnt, 13);

    // CPU write during hold
    step("t4_ir", 1'b1, 32'h33, 1'b0, 1'b1, 32'h77);
    idle("t4a", 32'h33, 2);
    step("t4_wr", 1'b1, 32'h44, 1'b1, 1'b0, 32'h0);
    idle("t4b", 32'h44, 8);
    chk("t4_pend_clr", 32'(bus.cpu_pend), 32'h0);

    // simultaneous ir_valid + cpu_wr in S_CPU
    step("t5_both", 1'b1, 32'h55, 1'b1, 1'b1, 32'h99);
    chk("t5_pend", 32'(bus.cpu_pend), 32'h1);
    idle("t5a", 32'h55, 9);
    // ir_valid on the counter==0 cycle
    own_cnt = 0;
    step("t5_ir1", 1'b1, 32'h66, 1'b0, 1'b1, 32'h10);
    if (bus.owner) own_cnt++;
    idle("t5b", 32'h66, H - 1);
    step("t5_ir2", 1'b1, 32'h66, 1'b0, 1'b1, 32'h20);
    if (bus.owner) own_cnt++;
    idle("t5c", 32'h66, 10);
    chk("t5_owncnt", own_cnt, 2 * H);

    // async reset mid-window
    step("t6_ir", 1'b1, 32'h88, 1'b0, 1'b1, 32'hEE);
    idle("t6a", 32'h88, 3);
    #3;
    Rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6_disp", bus.disp_data, 32'h0);
    chk("t6_en", 32'(bus.en), 32'h0);
    chk("t6_owner", 32'(bus.owner), 32'h0);
    chk("t6_pend", 32'(bus.cpu_pend), 32'h0);
    @(negedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    step("t6_trk", 1'b1, 32'hABCD0123, 1'b0, 1'b0, 32'h0);
    chk("t6_abs", bus.disp_data, 32'hABCD0123);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step("rnd",
           1'($urandom_range(0, 1)),
           32'($urandom),
           1'($urandom_range(0, 5) == 0),
           1'($urandom_range(0, 11) == 0),
           32'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
